// File: rtl/nonce_target_check_pkg.sv
// Shared SHA256 widths, byte-swap helper and job state encoding
// for the nonce/target check stage.
package nonce_target_check_pkg;

  localparam int HASH_WORD_NUM = 8;
  localparam int DATA_WID      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/nonce_target_check_fifo.sv
// Show-ahead (first-word-fall-through) synchronous FIFO.
// Writes while full are refused unless a pop happens on the same cycle.
module sync_fifo_fwft #(
  parameter int WID   = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en_i,
  input  logic [WID-1:0] wr_data_i,
  input  logic           rd_en_i,
  output logic [WID-1:0] rd_data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WID-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_wr;
  logic             do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  // Head reads as zero when empty so the output is clean after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

// File: rtl/nonce_target_check.sv
// Checks second-pass digests against the job target and queues winning nonces.
// Optional CHECK_STATS_EN adds per-job hash and hit counters.
module nonce_target_check #(
  parameter int HASH_WORD_NUM = 8,
  parameter int DATA_WID      = 32,
  parameter int NONCE_WID     = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WID       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_job_start,
  input  logic [NONCE_WID-1:0]              iv_nonce_base,
  input  logic [HASH_WORD_NUM*DATA_WID-1:0] iv_target,
  input  logic [CNT_WID-1:0]                iv_hash_total,
  input  logic [HASH_WORD_NUM*DATA_WID-1:0] iv_hash_data,
  input  logic                              i_hash_data_vld,
  output logic [NONCE_WID-1:0]              ov_hit_nonce,
  output logic                              o_hit_vld,
  input  logic                              i_hit_rdy,
  output logic                              o_hit_overflow,
  output logic                              o_busy,
`ifdef CHECK_STATS_EN
  output logic [47:0]                       ov_hash_cnt,
  output logic [15:0]                       ov_hit_cnt,
`endif
  output logic                              o_job_done
);

  import nonce_target_check_pkg::*;

  localparam int HW = HASH_WORD_NUM * DATA_WID;

  state_e                   state_q;
  logic                     drain_cnt_q;
  logic [NONCE_WID-1:0]     cur_nonce_q;
  logic [NONCE_WID-1:0]     s1_nonce_q;
  logic [NONCE_WID-1:0]     s2_nonce_q;
  logic [HW-1:0]            target_q;
  logic [CNT_WID-1:0]       total_q;
  logic [CNT_WID-1:0]       cnt_q;
  logic [CNT_WID-1:0]       cnt_inc;
  logic [HASH_WORD_NUM-1:0] lt_d;
  logic [HASH_WORD_NUM-1:0] eq_d;
  logic [HASH_WORD_NUM-1:0] lt_q;
  logic [HASH_WORD_NUM-1:0] eq_q;
  logic                     s1_vld_q;
  logic                     s2_vld_q;
  logic                     s2_hit_q;
  logic                     hit_d;
  logic                     job_done_q;
  logic                     overflow_q;
  logic                     acc;
  logic                     push_req;
  logic                     pop;
  logic                     fifo_wr;
  logic                     fifo_full;
  logic                     fifo_empty;

  // A start on the same cycle as a result wins; that result is dropped.
  assign acc     = i_hash_data_vld && (state_q == ST_RUN) && !i_job_start;
  assign cnt_inc = cnt_q + CNT_WID'(1);

  always_comb begin
    lt_d = '0;
    eq_d = '0;
    for (int k = 0; k < HASH_WORD_NUM; k++) begin
      lt_d[k] = bswap32(iv_hash_data[k*DATA_WID +: DATA_WID]) <
                target_q[k*DATA_WID +: DATA_WID];
      eq_d[k] = bswap32(iv_hash_data[k*DATA_WID +: DATA_WID]) ==
                target_q[k*DATA_WID +: DATA_WID];
    end
  end

  // Higher words override lower ones; all-equal means V == T, a hit.
  always_comb begin
    hit_d = 1'b1;
    for (int k = 0; k < HASH_WORD_NUM; k++) begin
      if (lt_q[k])       hit_d = 1'b1;
      else if (!eq_q[k]) hit_d = 1'b0;
    end
  end

  assign push_req = s2_vld_q && s2_hit_q && !i_job_start;
  assign pop      = o_hit_vld && i_hit_rdy;
  assign fifo_wr  = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 1'b0;
      cur_nonce_q <= '0;
      s1_nonce_q  <= '0;
      s2_nonce_q  <= '0;
      target_q    <= '0;
      total_q     <= '0;
      cnt_q       <= '0;
      lt_q        <= '0;
      eq_q        <= '0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_hit_q    <= 1'b0;
      job_done_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      job_done_q <= 1'b0;
      s1_vld_q   <= acc;
      s2_vld_q   <= s1_vld_q && !i_job_start;
      s2_hit_q   <= hit_d;
      s2_nonce_q <= s1_nonce_q;
      if (acc) begin
        lt_q        <= lt_d;
        eq_q        <= eq_d;
        s1_nonce_q  <= cur_nonce_q;
        cur_nonce_q <= cur_nonce_q + NONCE_WID'(1);
        cnt_q       <= cnt_inc;
      end
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
      if (i_job_start) begin
        state_q     <= ST_RUN;
        drain_cnt_q <= 1'b0;
        cur_nonce_q <= iv_nonce_base;
        target_q    <= iv_target;
        total_q     <= iv_hash_total;
        cnt_q       <= '0;
        overflow_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            if (acc && (total_q != '0) && (cnt_inc == total_q)) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= 1'b0;
            end
          end
          ST_DRAIN: begin
            if (drain_cnt_q) begin
              state_q    <= ST_DONE;
              job_done_q <= 1'b1;
            end else begin
              drain_cnt_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sync_fifo_fwft #(
    .WID   (NONCE_WID),
    .DEPTH (FIFO_DEPTH)
  ) u_hit_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (s2_nonce_q),
    .rd_en_i   (i_hit_rdy),
    .rd_data_o (ov_hit_nonce),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign o_hit_vld      = !fifo_empty;
  assign o_hit_overflow = overflow_q;
  assign o_busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_job_done     = job_done_q;

`ifdef CHECK_STATS_EN
  logic [47:0] hash_cnt_q;
  logic [15:0] hit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || i_job_start) begin
      hash_cnt_q <= '0;
      hit_cnt_q  <= '0;
    end else begin
      if (acc && (hash_cnt_q != '1)) hash_cnt_q <= hash_cnt_q + 48'd1;
      if (push_req && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 16'd1;
    end
  end

  assign ov_hash_cnt = hash_cnt_q;
  assign ov_hit_cnt  = hit_cnt_q;
`endif

endmodule

// File: tb/tb_nonce_target_check.sv
// Scoreboard bench for nonce_target_check: directed boundary cases
// plus randomized jobs against a 256-bit arithmetic reference model.
`timescale 1ns/1ps
module tb_nonce_target_check;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_job_start;
  logic [31:0]  iv_nonce_base;
  logic [255:0] iv_target;
  logic [31:0]  iv_hash_total;
  logic [255:0] iv_hash_data;
  logic         i_hash_data_vld;
  logic [31:0]  ov_hit_nonce;
  logic         o_hit_vld;
  logic         i_hit_rdy;
  logic         o_hit_overflow;
  logic         o_busy;
  logic         o_job_done;
`ifdef CHECK_STATS_EN
  logic [47:0]  ov_hash_cnt;
  logic [15:0]  ov_hit_cnt;
`endif

  always #5 clk = ~clk;

  nonce_target_check #(
    .HASH_WORD_NUM (8),
    .DATA_WID      (32),
    .NONCE_WID     (32),
    .FIFO_DEPTH    (DEPTH),
    .CNT_WID       (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_job_start     (i_job_start),
    .iv_nonce_base   (iv_nonce_base),
    .iv_target       (iv_target),
    .iv_hash_total   (iv_hash_total),
    .iv_hash_data    (iv_hash_data),
    .i_hash_data_vld (i_hash_data_vld),
    .ov_hit_nonce    (ov_hit_nonce),
    .o_hit_vld       (o_hit_vld),
    .i_hit_rdy       (i_hit_rdy),
    .o_hit_overflow  (o_hit_overflow),
    .o_busy          (o_busy),
`ifdef CHECK_STATS_EN
    .ov_hash_cnt     (ov_hash_cnt),
    .ov_hit_cnt      (ov_hit_cnt),
`endif
    .o_job_done      (o_job_done)
  );

  typedef struct {
    logic [31:0] nonce;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   pops = 0;
  int   dones = 0;
  int   cyc_no = 0;

  logic [31:0]  m_nonce;
  logic [255:0] m_target;
  logic [31:0]  m_total;
  logic [31:0]  m_cnt;
  bit           m_active = 0;
  bit           m_final_pend = 0;
  int           m_final_cyc = -100;
  int           m_done_exp = 0;
  int           m_drops = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Word-wise byte swap; self-inverse, so it maps digest <-> value V.
  function automatic logic [255:0] swap_words(input logic [255:0] x);
    logic [255:0] d;
    logic [31:0]  w;
    for (int k = 0; k < 8; k++) begin
      w = x[32*k +: 32];
      d[32*k +: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end
    return d;
  endfunction

  function automatic bit model_hit(input logic [255:0] dig,
                                   input logic [255:0] tgt);
    return swap_words(dig) <= tgt;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: pops the scoreboard on every handshake and watches holds.
  bit          prev_stall = 0;
  logic [31:0] prev_nonce = '0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (o_job_done) dones++;
      if (prev_stall) check("hold_stable", ov_hit_nonce, prev_nonce);
      if (o_hit_vld && i_hit_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_hit: got %0h expected none", ov_hit_nonce);
        end else begin
          e = exp_q.pop_front();
          check("hit_nonce", ov_hit_nonce, e.nonce);
        end
        pops++;
      end
    end
    prev_stall = !rst && o_hit_vld && !i_hit_rdy;
    prev_nonce = ov_hit_nonce;
  end

  // One clock cycle of stimulus, with the reference model updated alongside.
  task automatic drive(input bit start, input bit vld,
                       input logic [255:0] dig, input logic [31:0] base,
                       input logic [255:0] tgt, input logic [31:0] tot);
    exp_t e;
    if (vld && m_active && !start) begin
      if (model_hit(dig, m_target)) begin
        if (!i_hit_rdy && exp_q.size() >= DEPTH) begin
          m_drops++;
        end else begin
          e.nonce = m_nonce;
          e.cyc   = cyc_no;
          exp_q.push_back(e);
        end
      end
      m_nonce++;
      m_cnt++;
      if (m_total != 0 && m_cnt == m_total) begin
        m_active     = 0;
        m_final_pend = 1;
        m_final_cyc  = cyc_no;
        m_done_exp++;
      end
    end
    if (start) begin
      // Results still inside the two pipeline stages are lost on abort.
      while (exp_q.size() > 0 && exp_q[$].cyc >= cyc_no - 2)
        void'(exp_q.pop_back());
      if (m_final_pend && m_final_cyc >= cyc_no - 2) m_done_exp--;
      m_final_pend = 0;
      m_active     = 1;
      m_nonce      = base;
      m_target     = tgt;
      m_total      = tot;
      m_cnt        = 0;
      m_drops      = 0;
    end
    i_job_start     = start;
    i_hash_data_vld = vld;
    iv_hash_data    = dig;
    iv_nonce_base   = base;
    iv_target       = tgt;
    iv_hash_total   = tot;
    @(posedge clk);
    #1;
    cyc_no++;
    i_job_start     = 1'b0;
    i_hash_data_vld = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, '0, '0);
  endtask

  task automatic send(input logic [255:0] dig);
    drive(0, 1, dig, '0, '0, '0);
  endtask

  task automatic start_job(input logic [31:0] base, input logic [255:0] tgt,
                           input logic [31:0] tot);
    drive(1, 0, '0, base, tgt, tot);
  endtask

  task automatic settle(input string name);
    step(6);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_done_cnt"}, dones, m_done_exp);
  endtask

  initial begin : stim
    logic [255:0] t;
    logic [255:0] v;
    int           p0;
    int           nlen;

    rst = 1'b1;
    i_job_start = 1'b0;
    i_hash_data_vld = 1'b0;
    iv_hash_data = '0;
    iv_nonce_base = '0;
    iv_target = '0;
    iv_hash_total = '0;
    i_hit_rdy = 1'b1;
    step(2);
    rst = 1'b0;
    check("rst_hit_vld", o_hit_vld, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_job_done, 0);
    check("rst_overflow", o_hit_overflow, 0);
    check("rst_nonce", ov_hit_nonce, 0);

    // Basic: three hits, latency and completion timing.
    start_job(32'h100, '1, 3);
    check("basic_busy", o_busy, 1);
    send(rnd256());
    send(rnd256());
    check("basic_lat_early", o_hit_vld, 0);
    send(rnd256());
    check("basic_lat_vld", o_hit_vld, 1);
    check("basic_lat_nonce", ov_hit_nonce, 32'h100);
    step(1);
    check("basic_done_early", o_job_done, 0);
    step(1);
    check("basic_done", o_job_done, 1);
    check("basic_idle", o_busy, 0);
    step(1);
    check("basic_done_pulse", o_job_done, 0);
    settle("basic");

    // Boundary compare with unbounded job; LSB of target set.
    t = rnd256();
    t[255] = 1'b0;
    t[255:224] = $urandom_range(1, 32'h7FFF_FFFF);
    t[0] = 1'b1;
    start_job(32'h5000, t, 0);
    send(swap_words(t));
    send(swap_words(t + 256'd1));
    send(swap_words(t ^ 256'd1));
    v = t;
    v[255:224] = t[255:224] - 32'd1;
    v[223:0] = '1;
    send(swap_words(v));
    v[255:224] = t[255:224] + 32'd1;
    v[223:0] = '0;
    send(swap_words(v));
    step(20);
    check("bound_busy_total0", o_busy, 1);
    t[0] = 1'b0;
    start_job(32'h6000, t, 0);
    send(swap_words(t | 256'd1));
    send(swap_words(t));
    settle("bound");

    // Nonce wrap.
    start_job(32'hFFFF_FFFE, '1, 4);
    for (int i = 0; i < 4; i++) send(rnd256());
    settle("wrap");

    // Backpressure: six hits into a four-entry FIFO.
    i_hit_rdy = 1'b0;
    start_job(32'h0000_A000, '1, 6);
    for (int i = 0; i < 6; i++) send(rnd256());
    step(4);
    check("bp_vld", o_hit_vld, 1);
    check("bp_head", ov_hit_nonce, 32'h0000_A000);
    check("bp_overflow", o_hit_overflow, m_drops != 0);
    p0 = pops;
    i_hit_rdy = 1'b1;
    step(8);
    check("bp_pops", pops - p0, DEPTH);
    check("bp_overflow_sticky", o_hit_overflow, 1);
    settle("bp");
    start_job(32'h0, '1, 1);
    check("bp_overflow_clear", o_hit_overflow, 0);
    send(rnd256());
    settle("bp2");

    // Abort with hits in both pipeline stages.
    start_job(32'h0000_B000, '1, 10);
    for (int i = 0; i < 4; i++) send(rnd256());
    start_job(32'h0000_C000, '1, 2);
    check("abort_busy", o_busy, 1);
    send(rnd256());
    send(rnd256());
    settle("abort");

    // Start coincident with a result: the result is ignored.
    drive(1, 1, rnd256(), 32'h0000_D000, '1, 1);
    send(rnd256());
    settle("start_vld");

    // Reset mid-job with a non-empty FIFO.
    i_hit_rdy = 1'b0;
    start_job(32'h0000_E000, '1, 0);
    send(rnd256());
    send(rnd256());
    step(4);
    check("rstmid_pre_vld", o_hit_vld, 1);
    rst = 1'b1;
    exp_q.delete();
    m_active = 0;
    step(1);
    rst = 1'b0;
    check("rstmid_vld", o_hit_vld, 0);
    check("rstmid_busy", o_busy, 0);
    check("rstmid_nonce", ov_hit_nonce, 0);
    for (int i = 0; i < 3; i++) send(rnd256());
    step(4);
    check("rstmid_ignored", o_hit_vld, 0);
    i_hit_rdy = 1'b1;
    settle("rstmid");

    // Randomized jobs, including aborts in RUN/DRAIN and near-target digests.
    for (int j = 0; j < 16; j++) begin
      t = rnd256();
      drive(1, $urandom_range(0, 3) == 0, rnd256(), $urandom, t,
            $urandom_range(0, 6));
      nlen = $urandom_range(2, 12);
      for (int n = 0; n < nlen; n++) begin
        v = ($urandom_range(0, 5) == 0) ? t : rnd256();
        if ($urandom_range(0, 7) == 0) v = t + 256'd1;
        drive(0, $urandom_range(0, 3) != 0, swap_words(v), '0, '0, '0);
      end
    end
    settle("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
